// File: rtl/varray_run_packer.sv
// Write-side front end for the run-length virtual array queue: merges a stream of
// strictly increasing (address, data) elements into runs and emits one queue write per run.
module varray_run_packer #(
  parameter int VIRTUAL_ELEMENT_WIDTH = 18,
  parameter int VIRTUAL_ADDR_BITS     = 16,
  parameter int MAX_RUN               = 16,
  parameter bit SKIP_ZERO             = 1'b1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [VIRTUAL_ADDR_BITS-1:0]     in_addr,
  input  logic [VIRTUAL_ELEMENT_WIDTH-1:0] in_dat,
  input  logic                             in_last,
  input  logic                             flush,
  output logic                             we,
  output logic [VIRTUAL_ADDR_BITS-1:0]     write_addr,
  output logic [4:0]                       write_addr_len,
  output logic [VIRTUAL_ELEMENT_WIDTH-1:0] dat_w,
  output logic [VIRTUAL_ADDR_BITS-1:0]     varray_len,
  output logic                             run_open,
  output logic                             err
);

  localparam int         AW      = VIRTUAL_ADDR_BITS;
  localparam int         DW      = VIRTUAL_ELEMENT_WIDTH;
  localparam logic [4:0] MAX_LEN = 5'(MAX_RUN);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    OPEN       = 2'd1,
    FLUSH_PEND = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   run_start_q, run_start_d;
  logic [4:0]      run_len_q, run_len_d;
  logic [DW-1:0]   run_dat_q, run_dat_d;
  logic            sealed_q, sealed_d;
  logic [AW-1:0]   last_addr_q, last_addr_d;
  logic            have_last_q, have_last_d;
  logic            err_q, err_d;

  logic            we_q;
  logic [AW-1:0]   write_addr_q;
  logic [4:0]      write_addr_len_q;
  logic [DW-1:0]   dat_w_q;
  logic [AW-1:0]   varray_len_q;

  logic            emit_d;
  logic [AW-1:0]   emit_start;
  logic [4:0]      emit_len;
  logic [DW-1:0]   emit_dat;

  logic            accept;
  logic            is_zero;
  logic            in_addr_top;
  logic            can_extend;
  logic [AW:0]     run_end;
  logic [AW:0]     emit_end;
  logic [AW-1:0]   emit_end_sat;

  assign in_ready = (state_q != FLUSH_PEND);
  assign run_open = (state_q != IDLE);
  assign accept   = in_valid && in_ready;

  // One extra bit so a run ending exactly at the top of the address space never wraps.
  assign run_end     = {1'b0, run_start_q} + {{(AW-4){1'b0}}, run_len_q};
  assign in_addr_top = &in_addr;
  assign is_zero     = SKIP_ZERO && (in_dat == '0);
  assign can_extend  = (state_q == OPEN) && !sealed_q && (in_dat == run_dat_q) &&
                       ({1'b0, in_addr} == run_end);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    run_start_d = run_start_q;
    run_len_d   = run_len_q;
    run_dat_d   = run_dat_q;
    sealed_d    = sealed_q;
    last_addr_d = last_addr_q;
    have_last_d = have_last_q;
    err_d       = err_q;
    emit_d      = 1'b0;
    emit_start  = run_start_q;
    emit_len    = run_len_q;
    emit_dat    = run_dat_q;

    if (state_q == FLUSH_PEND) begin
      emit_d  = 1'b1;
      state_d = IDLE;
    end else begin
      if (accept) begin
        if (have_last_q && (in_addr <= last_addr_q)) begin
          err_d = 1'b1;
        end else begin
          last_addr_d = in_addr;
          have_last_d = 1'b1;
          if (is_zero) begin
            if (state_q == OPEN) begin
              emit_d  = 1'b1;
              state_d = IDLE;
            end
          end else if (can_extend) begin
            run_len_d = run_len_q + 5'd1;
            sealed_d  = (run_len_d == MAX_LEN) || in_last || in_addr_top;
          end else begin
            emit_d      = (state_q == OPEN);
            run_start_d = in_addr;
            run_len_d   = 5'd1;
            run_dat_d   = in_dat;
            sealed_d    = in_last || (MAX_LEN == 5'd1) || in_addr_top;
            state_d     = OPEN;
          end
        end
      end

      // The element is handled first; a run it already closed defers the flush by one cycle.
      if (flush) begin
        if (emit_d) begin
          if (state_d == OPEN) state_d = FLUSH_PEND;
        end else if (state_d == OPEN) begin
          emit_d     = 1'b1;
          emit_start = run_start_d;
          emit_len   = run_len_d;
          emit_dat   = run_dat_d;
          state_d    = IDLE;
        end
      end
    end
  end

  assign emit_end     = {1'b0, emit_start} + {{(AW-4){1'b0}}, emit_len};
  assign emit_end_sat = emit_end[AW] ? {AW{1'b1}} : emit_end[AW-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      run_start_q      <= '0;
      run_len_q        <= '0;
      run_dat_q        <= '0;
      sealed_q         <= 1'b0;
      last_addr_q      <= '0;
      have_last_q      <= 1'b0;
      err_q            <= 1'b0;
      we_q             <= 1'b0;
      write_addr_q     <= '0;
      write_addr_len_q <= '0;
      dat_w_q          <= '0;
      varray_len_q     <= '0;
    end else begin
      state_q     <= state_d;
      run_start_q <= run_start_d;
      run_len_q   <= run_len_d;
      run_dat_q   <= run_dat_d;
      sealed_q    <= sealed_d;
      last_addr_q <= last_addr_d;
      have_last_q <= have_last_d;
      err_q       <= err_d;
      we_q        <= emit_d;
      if (emit_d) begin
        write_addr_q     <= emit_start;
        write_addr_len_q <= emit_len;
        dat_w_q          <= emit_dat;
        if (emit_end_sat > varray_len_q) varray_len_q <= emit_end_sat;
      end
    end
  end

  assign we             = we_q;
  assign write_addr     = write_addr_q;
  assign write_addr_len = write_addr_len_q;
  assign dat_w          = dat_w_q;
  assign varray_len     = varray_len_q;
  assign err            = err_q;

endmodule

// File: tb/tb_varray_run_packer.sv
// Scenario bench for varray_run_packer: expected writes are queued as stimulus is driven
// and matched in order against each we pulse; per-scenario timing/flag checks are inline.
module tb_varray_run_packer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_addr;
  logic [17:0] in_dat;
  logic        in_last;
  logic        flush;
  logic        we;
  logic [15:0] write_addr;
  logic [4:0]  write_addr_len;
  logic [17:0] dat_w;
  logic [15:0] varray_len;
  logic        run_open;
  logic        err;

  typedef struct {
    logic [15:0] addr;
    logic [4:0]  len;
    logic [17:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  varray_run_packer dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_addr        (in_addr),
    .in_dat         (in_dat),
    .in_last        (in_last),
    .flush          (flush),
    .we             (we),
    .write_addr     (write_addr),
    .write_addr_len (write_addr_len),
    .dat_w          (dat_w),
    .varray_len     (varray_len),
    .run_open       (run_open),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push(input logic [15:0] a, input logic [4:0] l, input logic [17:0] d);
    exp_t e;
    e.addr = a;
    e.len  = l;
    e.dat  = d;
    exp_q.push_back(e);
  endfunction

  // One clock: drive on the falling edge, sample 1 ns after the rising edge, score any write.
  task automatic tick(input logic v, input logic [15:0] a, input logic [17:0] d,
                      input logic l, input logic f);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in_addr  = a;
    in_dat   = d;
    in_last  = l;
    flush    = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    flush    = 1'b0;
    if (we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d len=%0d dat=%0d, required no write",
                 write_addr, write_addr_len, dat_w);
      end else begin
        e = exp_q.pop_front();
        if ({write_addr, write_addr_len, dat_w} !== {e.addr, e.len, e.dat}) begin
          errors++;
          $display("FAIL write_content: got addr=%0d len=%0d dat=%0d, required addr=%0d len=%0d dat=%0d",
                   write_addr, write_addr_len, dat_w, e.addr, e.len, e.dat);
        end
      end
    end
  endtask

  task automatic idle();
    tick(1'b0, 16'd0, 18'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d writes still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({we, write_addr, write_addr_len, dat_w, varray_len, run_open, err, in_ready} !==
        {1'b0, 16'd0, 5'd0, 18'd0, 16'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: got we=%b wa=%0d len=%0d dat=%0d vlen=%0d open=%b err=%b rdy=%b, required 0s with in_ready=1",
               we, write_addr, write_addr_len, dat_w, varray_len, run_open, err, in_ready);
    end
  endtask

  task automatic test_merge();
    do_reset();
    tick(1'b1, 16'd10, 18'd5, 1'b0, 1'b0);
    tick(1'b1, 16'd11, 18'd5, 1'b0, 1'b0);
    tick(1'b1, 16'd12, 18'd5, 1'b0, 1'b0);
    checks++;
    if ({we, run_open} !== 2'b01) begin
      errors++;
      $display("FAIL merge_pending: got we=%b open=%b, required we=0 open=1", we, run_open);
    end
    push(16'd10, 5'd3, 18'd5);
    tick(1'b1, 16'd13, 18'd7, 1'b0, 1'b0);
    checks++;
    if ({we, run_open, varray_len} !== {1'b1, 1'b1, 16'd13}) begin
      errors++;
      $display("FAIL merge_emit: got we=%b open=%b vlen=%0d, required we=1 open=1 vlen=13", we, run_open, varray_len);
    end
    push(16'd13, 5'd1, 18'd7);
    tick(1'b0, 16'd0, 18'd0, 1'b0, 1'b1);
    checks++;
    if ({we, run_open, varray_len} !== {1'b1, 1'b0, 16'd14}) begin
      errors++;
      $display("FAIL merge_flush: got we=%b open=%b vlen=%0d, required we=1 open=0 vlen=14", we, run_open, varray_len);
    end
    drain("merge");
  endtask

  task automatic test_max_run();
    do_reset();
    push(16'd0, 5'd16, 18'd3);
    for (int i = 0; i < 17; i++) begin
      tick(1'b1, 16'(i), 18'd3, 1'b0, 1'b0);
      if (i == 15) begin
        checks++;
        if (we !== 1'b0) begin
          errors++;
          $display("FAIL max_run_early: got we=%b at 16th element, required 0", we);
        end
      end
    end
    checks++;
    if (we !== 1'b1) begin
      errors++;
      $display("FAIL max_run_emit: got we=%b after 17th element, required 1", we);
    end
    push(16'd16, 5'd1, 18'd3);
    tick(1'b0, 16'd0, 18'd0, 1'b0, 1'b1);
    checks++;
    if (varray_len !== 16'd17) begin
      errors++;
      $display("FAIL max_run_vlen: got %0d, required 17", varray_len);
    end
    drain("max_run");
  endtask

  task automatic test_sparse();
    do_reset();
    tick(1'b1, 16'd4, 18'd9, 1'b0, 1'b0);
    push(16'd4, 5'd1, 18'd9);
    tick(1'b1, 16'd5, 18'd0, 1'b0, 1'b0);
    checks++;
    if ({we, run_open} !== 2'b10) begin
      errors++;
      $display("FAIL sparse_zero_close: got we=%b open=%b, required we=1 open=0", we, run_open);
    end
    tick(1'b1, 16'd6, 18'd0, 1'b0, 1'b0);
    tick(1'b1, 16'd7, 18'd9, 1'b0, 1'b0);
    checks++;
    if ({we, run_open} !== 2'b01) begin
      errors++;
      $display("FAIL sparse_zero_skip: got we=%b open=%b, required we=0 open=1", we, run_open);
    end
    push(16'd7, 5'd1, 18'd9);
    tick(1'b0, 16'd0, 18'd0, 1'b0, 1'b1);
    checks++;
    if (varray_len !== 16'd8) begin
      errors++;
      $display("FAIL sparse_vlen: got %0d, required 8", varray_len);
    end
    drain("sparse");
  endtask

  task automatic test_gap_last();
    do_reset();
    tick(1'b1, 16'd0, 18'd2, 1'b1, 1'b0);
    push(16'd0, 5'd1, 18'd2);
    tick(1'b1, 16'd1, 18'd2, 1'b0, 1'b0);
    checks++;
    if (we !== 1'b1) begin
      errors++;
      $display("FAIL last_seal: got we=%b, required 1", we);
    end
    push(16'd1, 5'd1, 18'd2);
    tick(1'b0, 16'd0, 18'd0, 1'b0, 1'b1);
    tick(1'b1, 16'd2, 18'd2, 1'b0, 1'b0);
    push(16'd2, 5'd1, 18'd2);
    tick(1'b1, 16'd5, 18'd2, 1'b0, 1'b0);
    checks++;
    if ({we, run_open} !== 2'b11) begin
      errors++;
      $display("FAIL gap_break: got we=%b open=%b, required we=1 open=1", we, run_open);
    end
    push(16'd5, 5'd1, 18'd2);
    tick(1'b0, 16'd0, 18'd0, 1'b0, 1'b1);
    drain("gap_last");
  endtask

  task automatic test_flush_collision();
    do_reset();
    tick(1'b1, 16'd20, 18'd8, 1'b0, 1'b0);
    tick(1'b1, 16'd21, 18'd8, 1'b0, 1'b0);
    push(16'd20, 5'd2, 18'd8);
    push(16'd22, 5'd1, 18'd4);
    tick(1'b1, 16'd22, 18'd4, 1'b0, 1'b1);
    checks++;
    if ({we, in_ready, run_open} !== 3'b101) begin
      errors++;
      $display("FAIL collision_first: got we=%b rdy=%b open=%b, required we=1 rdy=0 open=1", we, in_ready, run_open);
    end
    tick(1'b0, 16'd0, 18'd0, 1'b0, 1'b1);
    checks++;
    if ({we, in_ready, run_open, varray_len} !== {3'b110, 16'd23}) begin
      errors++;
      $display("FAIL collision_second: got we=%b rdy=%b open=%b vlen=%0d, required we=1 rdy=1 open=0 vlen=23",
               we, in_ready, run_open, varray_len);
    end
    idle();
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL collision_quiet: got we=%b, required 0", we);
    end
    drain("collision");
  endtask

  task automatic test_top_address();
    do_reset();
    tick(1'b1, 16'hFFFE, 18'd6, 1'b0, 1'b0);
    tick(1'b1, 16'hFFFF, 18'd6, 1'b0, 1'b0);
    checks++;
    if ({we, run_open} !== 2'b01) begin
      errors++;
      $display("FAIL top_extend: got we=%b open=%b, required we=0 open=1", we, run_open);
    end
    push(16'hFFFE, 5'd2, 18'd6);
    tick(1'b0, 16'd0, 18'd0, 1'b0, 1'b1);
    drain("top_address");
  endtask

  task automatic test_error_reset();
    do_reset();
    tick(1'b1, 16'd30, 18'd1, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clean: got err=%b, required 0", err);
    end
    tick(1'b1, 16'd30, 18'd1, 1'b0, 1'b0);
    checks++;
    if ({err, run_open} !== 2'b11) begin
      errors++;
      $display("FAIL err_set: got err=%b open=%b, required err=1 open=1", err, run_open);
    end
    tick(1'b1, 16'd31, 18'd1, 1'b0, 1'b0);
    idle();
    checks++;
    if ({err, run_open, we} !== 3'b110) begin
      errors++;
      $display("FAIL err_sticky: got err=%b open=%b we=%b, required err=1 open=1 we=0", err, run_open, we);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({we, write_addr, write_addr_len, dat_w, varray_len, run_open, err, in_ready} !==
        {1'b0, 16'd0, 5'd0, 18'd0, 16'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_midrun: got we=%b wa=%0d len=%0d dat=%0d vlen=%0d open=%b err=%b rdy=%b, required 0s with in_ready=1",
               we, write_addr, write_addr_len, dat_w, varray_len, run_open, err, in_ready);
    end
    for (int i = 0; i < 4; i++) idle();
    drain("error_reset");
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_addr  = '0;
    in_dat   = '0;
    in_last  = 1'b0;
    flush    = 1'b0;
    test_reset();
    test_merge();
    test_max_run();
    test_sparse();
    test_gap_last();
    test_flush_collision();
    test_top_address();
    test_error_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
